// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the master mux: transfer types, owner codes, size/burst constants.
// Latency: none (types and constants only).
// Backpressure: none.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } ahb_owner_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

endpackage

// File: rtl/ahb_mux_perf.sv
// Saturating handover and data-phase stall counters for the AHB master mux.
// Latency: counts update on the clock edge that observes the event.
// Backpressure: none; observes hready only, never stalls the bus.
module ahb_mux_perf
    import ahb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        hready,
    input  ahb_owner_t  cur_own,
    input  ahb_owner_t  nxt_own,
    input  ahb_owner_t  data_own,
    output logic [31:0] perf_handover_cnt,
    output logic [31:0] perf_stall_cnt
);

    logic handover_evt;
    logic stall_evt;

    assign handover_evt = hready && (nxt_own != cur_own) &&
                          (cur_own != OWN_NONE) && (nxt_own != OWN_NONE);
    assign stall_evt    = !hready && (data_own != OWN_NONE);

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_handover_cnt <= 32'd0;
            perf_stall_cnt    <= 32'd0;
        end else begin
            if (handover_evt && (perf_handover_cnt != 32'hFFFF_FFFF))
                perf_handover_cnt <= perf_handover_cnt + 32'd1;
            if (stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Two-master AHB bus mux: registered address/data-phase ownership from arbiter grants.
// Latency: grant visible on the bus 1 clk after the first hready edge; wdata one hready beat later.
// Backpressure: hready=0 freezes both ownership phases. Optional AHB_MUX_PERF_EN adds perf counters.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hgrant_0,
    input  logic              hgrant_1,
    input  logic [1:0]        m0_htrans,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [DATA_W-1:0] m0_hwdata,
    input  logic [1:0]        m1_htrans,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic              m0_own,
    output logic              m1_own,
    input  logic              hready,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    output logic              hmaster,
    output logic              hmaster_vld
`ifdef AHB_MUX_PERF_EN
    ,
    output logic [31:0]       perf_handover_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    ahb_owner_t addr_own;
    ahb_owner_t data_own;
    ahb_owner_t addr_own_nxt;

    // Next address-phase owner: M0 has priority; only sampled when the bus advances
    always_comb begin
        addr_own_nxt = addr_own;
        if (hready) begin
            if (hgrant_0)
                addr_own_nxt = OWN_M0;
            else if (hgrant_1)
                addr_own_nxt = OWN_M1;
            else
                addr_own_nxt = OWN_NONE;
        end
    end

    // Ownership pipeline: the data phase inherits the address-phase owner each beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_own <= OWN_NONE;
            data_own <= OWN_NONE;
        end else if (hready) begin
            data_own <= addr_own;
            addr_own <= addr_own_nxt;
        end
    end

    // Address/control mux; an unowned bus drives an IDLE transfer with zeroed fields
    always_comb begin
        htrans = IDLE;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = HSIZE_BYTE;
        hburst = HBURST_SINGLE;
        case (addr_own)
            OWN_M0: begin
                htrans = m0_htrans;
                haddr  = m0_haddr;
                hwrite = m0_hwrite;
                hsize  = m0_hsize;
                hburst = m0_hburst;
            end
            OWN_M1: begin
                htrans = m1_htrans;
                haddr  = m1_haddr;
                hwrite = m1_hwrite;
                hsize  = m1_hsize;
                hburst = m1_hburst;
            end
            default: ;
        endcase
    end

    // Write data follows the data-phase owner, so it lags the address mux by one beat
    always_comb begin
        hwdata = '0;
        case (data_own)
            OWN_M0:  hwdata = m0_hwdata;
            OWN_M1:  hwdata = m1_hwdata;
            default: ;
        endcase
    end

    assign m0_own      = (addr_own == OWN_M0);
    assign m1_own      = (addr_own == OWN_M1);
    assign hmaster     = (addr_own == OWN_M1);
    assign hmaster_vld = (addr_own != OWN_NONE);

`ifdef AHB_MUX_PERF_EN
    ahb_mux_perf u_perf (
        .clk               (clk),
        .rstn              (rstn),
        .hready            (hready),
        .cur_own           (addr_own),
        .nxt_own           (addr_own_nxt),
        .data_own          (data_own),
        .perf_handover_cnt (perf_handover_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Self-checking bench for ahb_master_mux: vector table, hand sequences, random vs model.
// Latency: checks sampled 2ns after each rising edge.
// Backpressure: hready driven by the bench, randomly deasserted in the random phase.
module tb_ahb_master_mux;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          hgrant_0, hgrant_1, hready;
    logic [1:0]    m0_htrans, m1_htrans;
    logic [AW-1:0] m0_haddr, m1_haddr;
    logic          m0_hwrite, m1_hwrite;
    logic [2:0]    m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [DW-1:0] m0_hwdata, m1_hwdata;
    logic          m0_own, m1_own;
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [DW-1:0] hwdata;
    logic          hmaster, hmaster_vld;
`ifdef AHB_MUX_PERF_EN
    logic [31:0]   perf_handover_cnt, perf_stall_cnt;
`endif

    ahb_master_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn), .hgrant_0(hgrant_0), .hgrant_1(hgrant_1),
        .m0_htrans(m0_htrans), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
        .m1_htrans(m1_htrans), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
        .m0_own(m0_own), .m1_own(m1_own), .hready(hready),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hmaster(hmaster), .hmaster_vld(hmaster_vld)
`ifdef AHB_MUX_PERF_EN
        , .perf_handover_cnt(perf_handover_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: owner codes 0 = none, 1 = master 0, 2 = master 1
    int mdl_a = 0;
    int mdl_d = 0;
    int mdl_ho = 0;
    int mdl_st = 0;

    typedef struct {
        logic g0;
        logic g1;
        logic rdy;
        int   a;
        int   d;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected bus view for given owners, derived from the master inputs currently driven
    task automatic exp_bus(input string tag, input int a, input int d);
        logic [1:0]    e_tr;
        logic [AW-1:0] e_ad;
        logic          e_wr;
        logic [2:0]    e_sz, e_bu;
        logic [DW-1:0] e_wd;
        e_tr = 2'b00; e_ad = '0; e_wr = 1'b0; e_sz = 3'd0; e_bu = 3'd0; e_wd = '0;
        if (a == 1) begin
            e_tr = m0_htrans; e_ad = m0_haddr; e_wr = m0_hwrite; e_sz = m0_hsize; e_bu = m0_hburst;
        end else if (a == 2) begin
            e_tr = m1_htrans; e_ad = m1_haddr; e_wr = m1_hwrite; e_sz = m1_hsize; e_bu = m1_hburst;
        end
        if (d == 1) e_wd = m0_hwdata;
        else if (d == 2) e_wd = m1_hwdata;
        chk({tag, "_htrans"}, 64'(htrans), 64'(e_tr));
        chk({tag, "_haddr"},  64'(haddr),  64'(e_ad));
        chk({tag, "_hwrite"}, 64'(hwrite), 64'(e_wr));
        chk({tag, "_hsize"},  64'(hsize),  64'(e_sz));
        chk({tag, "_hburst"}, 64'(hburst), 64'(e_bu));
        chk({tag, "_hwdata"}, 64'(hwdata), 64'(e_wd));
        chk({tag, "_m0_own"}, 64'(m0_own), 64'(a == 1));
        chk({tag, "_m1_own"}, 64'(m1_own), 64'(a == 2));
        chk({tag, "_hmaster"}, 64'(hmaster), 64'(a == 2));
        chk({tag, "_hmaster_vld"}, 64'(hmaster_vld), 64'(a != 0));
`ifdef AHB_MUX_PERF_EN
        chk({tag, "_perf_ho"}, 64'(perf_handover_cnt), 64'(mdl_ho));
        chk({tag, "_perf_st"}, 64'(perf_stall_cnt), 64'(mdl_st));
`endif
    endtask

    // One clock: model advances on the edge from pre-edge inputs, then outputs settle
    task automatic cycle();
        int nxt;
        @(posedge clk);
        if (rstn) begin
            nxt = hgrant_0 ? 1 : (hgrant_1 ? 2 : 0);
            if (hready) begin
                if (nxt != mdl_a && nxt != 0 && mdl_a != 0) mdl_ho++;
                mdl_d = mdl_a;
                mdl_a = nxt;
            end else if (mdl_d != 0) begin
                mdl_st++;
            end
        end
        #2;
    endtask

    task automatic set_grants(input logic g0, input logic g1, input logic rdy);
        hgrant_0 = g0; hgrant_1 = g1; hready = rdy;
    endtask

    initial begin
        rstn = 1'b0;
        set_grants(1'b0, 1'b0, 1'b1);
        m0_htrans = NONSEQ; m0_haddr = 32'h100; m0_hwrite = 1'b1;
        m0_hsize = HSIZE_WORD; m0_hburst = HBURST_SINGLE; m0_hwdata = 32'h1111_0001;
        m1_htrans = NONSEQ; m1_haddr = 32'h300; m1_hwrite = 1'b0;
        m1_hsize = HSIZE_HALF; m1_hburst = HBURST_INCR; m1_hwdata = 32'h2222_0002;

        // Vector table: grants/hready applied before the edge, owners expected after it
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1, 1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1, 2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 0, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 0, 0};

        #12;
        exp_bus("reset", 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_grants(tbl[i].g0, tbl[i].g1, tbl[i].rdy);
            cycle();
            exp_bus($sformatf("vec%0d", i), tbl[i].a, tbl[i].d);
        end

        // Handover overlap: M1 address phase alongside the M0 write data phase
        m0_haddr = 32'h200; m0_hwdata = 32'hA5;
        set_grants(1'b1, 1'b0, 1'b1);
        cycle();
        chk("ovl_m0_addr", 64'(haddr), 64'h200);
        set_grants(1'b0, 1'b1, 1'b1);
        cycle();
        chk("ovl_haddr", 64'(haddr), 64'h300);
        chk("ovl_hwdata", 64'(hwdata), 64'hA5);
        chk("ovl_hmaster", 64'(hmaster), 64'd1);
        cycle();
        chk("ovl_m1_data", 64'(hwdata), 64'h2222_0002);

        // Reset during an M1 data phase drops both phases without a clock edge
        #3;
        rstn = 1'b0;
        mdl_a = 0; mdl_d = 0; mdl_ho = 0; mdl_st = 0;
        #1;
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_hwdata", 64'(hwdata), 64'd0);
        chk("rst_hmaster_vld", 64'(hmaster_vld), 64'd0);
`ifdef AHB_MUX_PERF_EN
        chk("rst_perf_ho", 64'(perf_handover_cnt), 64'd0);
        chk("rst_perf_st", 64'(perf_stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_grants(1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
            m0_htrans = 2'($urandom); m0_haddr = $urandom; m0_hwrite = 1'($urandom);
            m0_hsize = 3'($urandom); m0_hburst = 3'($urandom); m0_hwdata = $urandom;
            m1_htrans = 2'($urandom); m1_haddr = $urandom; m1_hwrite = 1'($urandom);
            m1_hsize = 3'($urandom); m1_hburst = 3'($urandom); m1_hwdata = $urandom;
            cycle();
            exp_bus($sformatf("rnd%0d", i), mdl_a, mdl_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
